// File: rtl/divider_pkg.sv
// Shared types for the sequential restoring divider.
// FSM state encoding used by the top level.
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step.
// Shift in the next dividend bit and subtract the divisor if it fits.
module divider_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] r_i,
  input  logic         q_msb_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] r_o,
  output logic         q_bit_o
);

  logic [N:0] shifted;
  logic [N:0] trial;

  // Trial subtraction at N+1 bits; the MSB is the borrow.
  always_comb begin
    shifted = {r_i, q_msb_i};
    trial   = shifted - {1'b0, d_i};
    q_bit_o = ~trial[N];
    r_o     = trial[N] ? shifted[N-1:0] : trial[N-1:0];
  end

endmodule

// File: rtl/restoring_divider_n.sv
// Unsigned N-bit restoring divider, one quotient bit per clock.
// Valid/ready on both sides; results held in S_DONE until taken.
module restoring_divider_n
  import divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  r_nxt;
  logic          q_bit;

  divider_step #(.N(N)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[N-1]),
    .d_i     (d_q),
    .r_o     (r_nxt),
    .q_bit_o (q_bit)
  );

  // Next-state and datapath update; registers hold by default.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = CW'(N - 1);
            dbz_d   = 1'b0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        r_d = r_nxt;
        q_d = {q_q[N-2:0], q_bit};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_n.sv
// Directed bench for restoring_divider_n.
// 32-bit and 8-bit instances exercised in turn.
module tb_restoring_divider_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv32 = 1'b0;
  logic        ir32;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        ov32;
  logic        or32 = 1'b0;
  logic [31:0] q32;
  logic [31:0] r32;
  logic        z32;

  logic        iv8 = 1'b0;
  logic        ir8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ov8;
  logic        or8 = 1'b0;
  logic [7:0]  q8;
  logic [7:0]  r8;
  logic        z8;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  restoring_divider_n #(.N(32)) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (iv32),
    .in_ready    (ir32),
    .dividend    (a32),
    .divisor     (b32),
    .out_valid   (ov32),
    .out_ready   (or32),
    .quotient    (q32),
    .remainder   (r32),
    .div_by_zero (z32)
  );

  restoring_divider_n #(.N(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (iv8),
    .in_ready    (ir8),
    .dividend    (a8),
    .divisor     (b8),
    .out_valid   (ov8),
    .out_ready   (or8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one 32-bit op; lat counts cycles from accept to out_valid.
  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic z, output int lat);
    int w;
    w = 0;
    while (!ir32 && w < 200) begin
      tick();
      w++;
    end
    iv32 = 1'b1;
    a32  = a;
    b32  = b;
    tick();
    iv32 = 1'b0;
    lat  = 1;
    while (!ov32 && lat < 200) begin
      tick();
      lat++;
    end
    q = q32;
    r = r32;
    z = z32;
    or32 = 1'b1;
    tick();
    or32 = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({ir32, ov32, q32, r32, z32} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0})
      $display("FAIL reset32: got ir=%b ov=%b q=%h r=%h z=%b want 1 0 0 0 0",
               ir32, ov32, q32, r32, z32);
    else pass_cnt++;
    total_cnt++;
    if ({ir8, ov8, q8, r8, z8} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0})
      $display("FAIL reset8: got ir=%b ov=%b q=%h r=%h z=%b want 1 0 0 0 0",
               ir8, ov8, q8, r8, z8);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] q, r;
    logic z;
    int lat;
    run32(32'd100, 32'd7, q, r, z, lat);
    total_cnt++;
    if ({q, r, z} !== {32'd14, 32'd2, 1'b0})
      $display("FAIL div_100_7: got q=%0d r=%0d z=%b want 14 2 0", q, r, z);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 33)
      $display("FAIL lat_100_7: got %0d want 33", lat);
    else pass_cnt++;
    total_cnt++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0)
      $display("FAIL idle_after: got ir=%b ov=%b want 1 0", ir32, ov32);
    else pass_cnt++;
    run32(32'd7, 32'd100, q, r, z, lat);
    total_cnt++;
    if ({q, r, z} !== {32'd0, 32'd7, 1'b0})
      $display("FAIL div_7_100: got q=%0d r=%0d z=%b want 0 7 0", q, r, z);
    else pass_cnt++;
    run32(32'hFFFFFFFF, 32'd1, q, r, z, lat);
    total_cnt++;
    if ({q, r, z} !== {32'hFFFFFFFF, 32'd0, 1'b0})
      $display("FAIL div_max_1: got q=%h r=%h z=%b want ffffffff 0 0", q, r, z);
    else pass_cnt++;
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, q, r, z, lat);
    total_cnt++;
    if ({q, r, z} !== {32'd1, 32'd0, 1'b0})
      $display("FAIL div_max_max: got q=%h r=%h z=%b want 1 0 0", q, r, z);
    else pass_cnt++;
    run32(32'hFFFFFFFF, 32'h80000000, q, r, z, lat);
    total_cnt++;
    if ({q, r} !== {32'd1, 32'h7FFFFFFF})
      $display("FAIL div_max_msb: got q=%h r=%h want 1 7fffffff", q, r);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    logic z;
    int lat;
    run32(32'd42, 32'd0, q, r, z, lat);
    total_cnt++;
    if ({q, r, z} !== {32'hFFFFFFFF, 32'd42, 1'b1})
      $display("FAIL div_by_zero: got q=%h r=%0d z=%b want ffffffff 42 1", q, r, z);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 1)
      $display("FAIL lat_dbz: got %0d want 1", lat);
    else pass_cnt++;
  endtask

  task automatic test_stall_ignore();
    int w;
    iv32 = 1'b1;
    a32  = 32'd12345;
    b32  = 32'd100;
    tick();
    a32 = 32'd999;
    b32 = 32'd3;
    for (int i = 0; i < 6; i++) tick();
    total_cnt++;
    if (ir32 !== 1'b0)
      $display("FAIL busy_ready: got in_ready=%b want 0", ir32);
    else pass_cnt++;
    iv32 = 1'b0;
    tick();
    iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    w = 0;
    while (!ov32 && w < 200) begin
      tick();
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({ov32, ir32, q32, r32, z32} !== {1'b1, 1'b0, 32'd123, 32'd45, 1'b0})
        $display("FAIL stall_hold: got ov=%b ir=%b q=%0d r=%0d z=%b want 1 0 123 45 0",
                 ov32, ir32, q32, r32, z32);
      else pass_cnt++;
    end
    or32 = 1'b1;
    tick();
    or32 = 1'b0;
    total_cnt++;
    if ({ov32, ir32, q32, r32} !== {1'b0, 1'b1, 32'd123, 32'd45})
      $display("FAIL after_take: got ov=%b ir=%b q=%0d r=%0d want 0 1 123 45",
               ov32, ir32, q32, r32);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r;
    logic z;
    int lat;
    iv32 = 1'b1;
    a32  = 32'd55555;
    b32  = 32'd77;
    tick();
    iv32 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({ir32, ov32, q32, r32} !== {1'b1, 1'b0, 32'd0, 32'd0})
      $display("FAIL reset_mid: got ir=%b ov=%b q=%h r=%h want 1 0 0 0",
               ir32, ov32, q32, r32);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    run32(32'd1000, 32'd10, q, r, z, lat);
    total_cnt++;
    if ({q, r, z} !== {32'd100, 32'd0, 1'b0})
      $display("FAIL div_1000_10: got q=%0d r=%0d z=%b want 100 0 0", q, r, z);
    else pass_cnt++;
  endtask

  task automatic test_n8();
    int divs[16] = '{0, 1, 2, 3, 5, 7, 8, 13, 16, 100, 127, 128, 200, 254, 255, 9};
    int errs;
    int w;
    logic [7:0] eq, er;
    logic ez;
    errs = 0;
    foreach (divs[k]) begin
      for (int a = 0; a < 256; a += 5) begin
        for (int t = 0; t < 2; t++) begin
          logic [7:0] av;
          av = (t == 0) ? 8'(a) : 8'(255 - a);
          if (divs[k] == 0) begin
            eq = 8'hFF;
            er = av;
            ez = 1'b1;
          end else begin
            eq = 8'(int'(av) / divs[k]);
            er = 8'(int'(av) % divs[k]);
            ez = 1'b0;
          end
          w = 0;
          while (!ir8 && w < 50) begin
            tick();
            w++;
          end
          iv8 = 1'b1;
          a8  = av;
          b8  = 8'(divs[k]);
          tick();
          iv8 = 1'b0;
          w = 0;
          while (!ov8 && w < 50) begin
            tick();
            w++;
          end
          w = $urandom_range(0, 3);
          for (int s = 0; s < w; s++) tick();
          total_cnt++;
          if ({ov8, q8, r8, z8} !== {1'b1, eq, er, ez}) begin
            if (errs < 10)
              $display("FAIL n8 %0d/%0d: got ov=%b q=%0d r=%0d z=%b want 1 %0d %0d %b",
                       av, divs[k], ov8, q8, r8, z8, eq, er, ez);
            errs++;
          end else pass_cnt++;
          or8 = 1'b1;
          tick();
          or8 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #7;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_div_zero();
    test_stall_ignore();
    test_reset_mid();
    test_n8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
